ecc_decode_pipe: RTL
====================

# ecc_decode_pipe

Pipelined SECDED (Hamming + overall parity) decoder with a valid/ready stream on each side. It sits on the read path of ECC-protected SRAMs and register files. It takes codewords produced by the matching encoder, corrects single-bit errors, flags double-bit errors and optionally counts both. Widths come from the shared ECC package functions `get_parity_width` and `get_cw_width`.

## Interface
- `DataWidth`, 32: payload bits.
- `CntWidth`, 16: width of each error counter.
- Derived: `ParWidth = get_parity_width(DataWidth)`, `CwWidth = get_cw_width(DataWidth)`, `EncWidth = CwWidth + 1`.
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `in_data_i` in `EncWidth`: codeword.
- `in_valid_i` in 1 / `in_ready_o` out 1: input handshake.
- `out_data_o` out `DataWidth`: decoded, corrected payload.
- `out_single_err_o` out 1: single error detected and corrected.
- `out_double_err_o` out 1: uncorrectable error; payload passed raw.
- `out_valid_o` out 1 / `out_ready_i` in 1: output handshake.
- `cnt_clr_i` in 1: clear both counters.
- `single_cnt_o` out `CntWidth`, `double_cnt_o` out `CntWidth`: error counters.

## Operation
- Codeword layout:
  - Bit 0 is the overall parity, even over the whole codeword.
  - Bits 1..`CwWidth` are Hamming positions. Power-of-two positions hold check bits.
  - The remaining positions hold data, LSB first in ascending position order.
- Syndrome `S`: the XOR of the indices i in 1..`CwWidth` where bit i = 1. `S` is `ParWidth` bits wide.
- `P`: the XOR of all `EncWidth` bits.
- Classification:
  - S=0, P=0: clean.
  - P=1, S=0: error in bit 0. Set single_err; data is unaffected.
  - P=1, 0<S≤CwWidth: flip bit S, then extract data. Set single_err.
  - P=1, S>CwWidth: set double_err; raw data.
  - P=0, S≠0: set double_err; raw data.
- Flag exclusivity: single_err and double_err are never both 1.
- Stage 1 registers the codeword, S and P.
- Stage 2 registers the corrected data and flags.
- Each stage has a valid bit and loads when it is empty or its contents leave in the same cycle. This gives full throughput with backpressure.
- `in_ready_o` = !v1 | (!v2 | out_ready_i).
- Counters:
  - Increment on an output handshake (`out_valid_o & out_ready_i`) carrying the matching flag.
  - Saturate at all-ones.
  - When `cnt_clr_i` coincides with an increment, clear wins and the counter is 0 next cycle.

## Timing
- Latency is 2 cycles, input handshake to `out_valid_o`, when unstalled. Throughput is 1 word per cycle.
- Reset values: `out_valid_o` = 0, `out_data_o` = 0, both flags 0, both counters 0, stage valid bits 0.
- `in_ready_o` = 1 in the cycle after reset.
- Output stability: while `out_valid_o` = 1 and `out_ready_i` = 0, all out_* signals hold stable.
- Full condition: both stages valid and `out_ready_i` = 0, so `in_ready_o` = 0. `in_ready_o` depends combinationally on `out_ready_i`; no other comb paths exist.
- Reset mid-stream drops in-flight words. No output handshake occurs in the reset cycle.
- Flags are only meaningful while `out_valid_o` = 1.

## Configuration
- `ECC_DECODE_ERR_CNT_EN` defined: counters and `cnt_clr_i` are functional as above.
- `ECC_DECODE_ERR_CNT_EN` undefined:
  - Counter registers are not instantiated.
  - `single_cnt_o` and `double_cnt_o` are tied to 0.
  - `cnt_clr_i` is ignored.
- Datapath behaviour is identical in both cases.

## Structure
- Add to the shared ECC package:
  - a function `get_enc_width(DataWidth)` returning `get_cw_width + 1`;
  - a helper `is_pow2(i)` giving check-bit position selection, used by both encoder and decoder so that the layouts match.
- One combinational sub-module, `ecc_syndrome`: computes `S` and `P` from a codeword. It is reusable by a future scrubber.
- Pipeline registers, handshake and counters stay in `ecc_decode_pipe`.

## Test plan
- DataWidth=32 gives ParWidth=6, CwWidth=38, EncWidth=39.
- All-zero codeword -> data 0x0, no flags. `out_valid_o` rises exactly 2 cycles after acceptance.
- Zero codeword with bit 3 flipped (data bit 0) -> data 0x0000_0000, single_err=1. Separately, bit 0 flipped -> data 0x0, single_err=1.
- Zero codeword with bits 3 and 5 flipped -> double_err=1, single_err=0, data 0x0000_0003 (raw).
- Push 4 words with `out_ready_i` = 0 for 6 cycles:
  - `in_ready_o` drops after 2 accepted words;
  - after release, all 4 words emerge in order with no duplicates;
  - output stays stable while stalled.
- With `ECC_DECODE_ERR_CNT_EN` and CntWidth=2:
  - 5 single-error words give `single_cnt_o` = 3 (saturated);
  - 1 double-error word stalled 3 cycles gives `double_cnt_o` = 1;
  - `cnt_clr_i` asserted with an increment gives 0 on both counters.
- Assert `rst_i` for 1 cycle with 2 words in flight -> `out_valid_o` = 0 next cycle, counters 0, no stale word emitted afterwards.

Source files
------------

// File: rtl/ecc_decode_pipe_pkg.sv
// ecc_decode_pipe_pkg: shared SECDED layout helpers and the decoder status type.
package ecc_decode_pipe_pkg;

    typedef enum logic [1:0] {
        ECC_CLEAN  = 2'd0,
        ECC_SINGLE = 2'd1,
        ECC_DOUBLE = 2'd2
    } ecc_status_e;

    // A position is a check-bit position when it is a power of two.
    function automatic logic is_pow2(input int i);
        return (i > 0) && ((i & (i - 1)) == 0);
    endfunction

    // Smallest r with 2^r >= data_width + r + 1.
    function automatic int get_parity_width(input int data_width);
        int r;
        r = 1;
        while ((1 << r) < data_width + r + 1) r++;
        return r;
    endfunction

    function automatic int get_cw_width(input int data_width);
        return data_width + get_parity_width(data_width);
    endfunction

    // Hamming positions plus the overall parity bit at position 0.
    function automatic int get_enc_width(input int data_width);
        return get_cw_width(data_width) + 1;
    endfunction

    // Codeword position holding data bit k: the k-th non-power-of-two position.
    function automatic int data_pos(input int k);
        int p;
        int n;
        p = 0;
        n = -1;
        while (n < k) begin
            p++;
            if (!is_pow2(p)) n++;
        end
        return p;
    endfunction

endpackage

// File: rtl/ecc_decode_pipe_syndrome.sv
// ecc_syndrome: combinational Hamming syndrome and overall parity of one codeword.
module ecc_syndrome
    import ecc_decode_pipe_pkg::*;
#(
    parameter int DataWidth = 32,
    localparam int ParWidth = get_parity_width(DataWidth),
    localparam int CwWidth = get_cw_width(DataWidth),
    localparam int EncWidth = get_enc_width(DataWidth)
) (
    input  logic [EncWidth-1:0] cw_i,
    output logic [ParWidth-1:0] syn_o,
    output logic                par_o
);

    // Syndrome is the XOR of the indices of every set Hamming position.
    always_comb begin
        syn_o = '0;
        for (int i = 1; i <= CwWidth; i++) begin
            if (cw_i[i]) syn_o = syn_o ^ ParWidth'(i);
        end
    end

    assign par_o = ^cw_i;

endmodule

// File: rtl/ecc_decode_pipe.sv
// ecc_decode_pipe: two-stage SECDED decoder with valid/ready streams and optional
// error counters enabled by ECC_DECODE_ERR_CNT_EN.
module ecc_decode_pipe
    import ecc_decode_pipe_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int CntWidth = 16,
    localparam int ParWidth = get_parity_width(DataWidth),
    localparam int CwWidth = get_cw_width(DataWidth),
    localparam int EncWidth = get_enc_width(DataWidth)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [EncWidth-1:0]  in_data_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic [DataWidth-1:0] out_data_o,
    output logic                 out_single_err_o,
    output logic                 out_double_err_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    input  logic                 cnt_clr_i,
    output logic [CntWidth-1:0]  single_cnt_o,
    output logic [CntWidth-1:0]  double_cnt_o
);

    logic                 v1_q, v1_d, v2_q, v2_d;
    logic [EncWidth-1:0]  cw1_q;
    logic [ParWidth-1:0]  s1_q, syn;
    logic                 p1_q, par;
    logic [DataWidth-1:0] data2_q, data_d;
    logic                 se2_q, se_d, de2_q, de_d;
    logic                 ready2, load1, load2;
    ecc_status_e          status;
    logic [EncWidth-1:0]  fixed;
    logic                 unused_fixed;

    ecc_syndrome #(.DataWidth(DataWidth)) u_syndrome (
        .cw_i  (in_data_i),
        .syn_o (syn),
        .par_o (par)
    );

    // A stage loads when empty or when its word leaves in the same cycle.
    assign ready2     = !v2_q | out_ready_i;
    assign in_ready_o = !v1_q | ready2;
    assign load1      = in_valid_i & in_ready_o;
    assign load2      = v1_q & ready2;
    assign v1_d       = load1 | (v1_q & !ready2);
    assign v2_d       = load2 | (v2_q & !out_ready_i);

    // Classify from S and P; S beyond the codeword means more than one flip.
    always_comb begin
        status = p1_q ? ((int'(s1_q) <= CwWidth) ? ECC_SINGLE : ECC_DOUBLE)
                      : ((s1_q != '0) ? ECC_DOUBLE : ECC_CLEAN);
        fixed  = cw1_q ^ ((status == ECC_SINGLE) ? (EncWidth'(1) << s1_q) : '0);
        se_d   = status == ECC_SINGLE;
        de_d   = status == ECC_DOUBLE;
    end

    // Check bits and the parity bit are consumed only through S and P.
    assign unused_fixed = ^fixed;

    for (genvar k = 0; k < DataWidth; k++) begin : g_ext
        localparam int P = data_pos(k);
        assign data_d[k] = fixed[P];
    end

    // Pipeline registers: stage 1 holds codeword/S/P, stage 2 the decoded result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            cw1_q   <= '0;
            s1_q    <= '0;
            p1_q    <= 1'b0;
            data2_q <= '0;
            se2_q   <= 1'b0;
            de2_q   <= 1'b0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            if (load1) begin
                cw1_q <= in_data_i;
                s1_q  <= syn;
                p1_q  <= par;
            end
            if (load2) begin
                data2_q <= data_d;
                se2_q   <= se_d;
                de2_q   <= de_d;
            end
        end
    end

    assign out_valid_o      = v2_q;
    assign out_data_o       = data2_q;
    assign out_single_err_o = se2_q;
    assign out_double_err_o = de2_q;

`ifdef ECC_DECODE_ERR_CNT_EN
    logic                fire;
    logic [CntWidth-1:0] single_cnt_q, single_cnt_d, double_cnt_q, double_cnt_d;

    assign fire = v2_q & out_ready_i;

    // Saturating counters; clear overrides a coincident increment.
    always_comb begin
        single_cnt_d = cnt_clr_i ? '0
                     : (fire && se2_q && !(&single_cnt_q)) ? single_cnt_q + CntWidth'(1)
                     : single_cnt_q;
        double_cnt_d = cnt_clr_i ? '0
                     : (fire && de2_q && !(&double_cnt_q)) ? double_cnt_q + CntWidth'(1)
                     : double_cnt_q;
    end

    // Counter state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            single_cnt_q <= '0;
            double_cnt_q <= '0;
        end else begin
            single_cnt_q <= single_cnt_d;
            double_cnt_q <= double_cnt_d;
        end
    end

    assign single_cnt_o = single_cnt_q;
    assign double_cnt_o = double_cnt_q;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr_i;
    assign single_cnt_o   = '0;
    assign double_cnt_o   = '0;
`endif

endmodule
